// File: rtl/calc_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calc_enc_seq
//  Purpose  : Push-button chord encoder. Three raw buttons are synchronised
//             and debounced. The FSM collects the union of buttons pressed
//             together (a chord). Once every button is released it emits one
//             encoded ALU operation through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEB_CYCLES : cycles a synchronised level must persist to be accepted
//                 (1..65535)
//    CNT_W      : debounce counter width, 2**CNT_W > DEB_CYCLES
//  Ports
//    clk        in   1  rising-edge clock
//    reset      in   1  asynchronous active-high reset
//    btnl/c/r   in   1  raw button levels, 1 = pressed
//    op_ready   in   1  consumer accepts alu_op when op_valid & op_ready
//    alu_op     out  4  encoded operation of the captured chord
//    op_valid   out  1  alu_op holds a pending operation
//    busy       out  1  FSM is collecting or emitting
//    overflow   out  1  sticky: a press was discarded while pending
// ============================================================================
module calc_enc_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnl,
  input  logic       btnc,
  input  logic       btnr,
  input  logic       op_ready,
  output logic [3:0] alu_op,
  output logic       op_valid,
  output logic       busy,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit order everywhere is {l, c, r}.
  logic [2:0] raw_w;
  logic [2:0] deb_w;

  assign raw_w = {btnl, btnc, btnr};

  // --------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter counts cycles in which the synchronised level disagrees
    // with the accepted level. It restarts whenever they agree, so only an
    // unbroken run of DEB_CYCLES disagreeing cycles flips the debounced state.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d = sync_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        deb_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        meta_q <= raw_w[i];
        sync_q <= meta_q;
        deb_q  <= deb_d;
        cnt_q  <= cnt_d;
      end
    end

    assign deb_w[i] = deb_q;
  end

  // --------------------------------------------------------------------------
  // Chord encoding
  // --------------------------------------------------------------------------
  function automatic logic [3:0] enc_chord(input logic [2:0] chord);
    logic [3:0] op;
    case (chord)
      3'b001:  op = 4'b0001;
      3'b010:  op = 4'b0010;
      3'b011:  op = 4'b0110;
      3'b100:  op = 4'b0100;
      3'b101:  op = 4'b1001;
      3'b110:  op = 4'b1010;
      3'b111:  op = 4'b0101;
      default: op = 4'b0000;  // empty chord cannot reach EMIT
    endcase
    return op;
  endfunction

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] chord_q;
  logic [3:0] alu_op_q;
  logic       op_valid_q;
  logic       busy_q;
  logic       overflow_q;
  // Set on acceptance: buttons still down from a discarded press, or from
  // the chord itself, must be released before a new chord may start.
  logic       wait_rel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      chord_q    <= 3'b000;
      alu_op_q   <= 4'b0000;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wait_rel_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wait_rel_q) begin
            if (deb_w == 3'b000) begin
              wait_rel_q <= 1'b0;
            end
          end else if (deb_w != 3'b000) begin
            state_q <= S_COLLECT;
            chord_q <= deb_w;
            busy_q  <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (deb_w == 3'b000) begin
            // Chord already holds every button seen; nothing to OR in.
            state_q    <= S_EMIT;
            alu_op_q   <= enc_chord(chord_q);
            op_valid_q <= 1'b1;
          end else begin
            chord_q <= chord_q | deb_w;
          end
        end

        S_EMIT: begin
          if (deb_w != 3'b000) begin
            overflow_q <= 1'b1;
          end
          if (op_ready) begin
            state_q    <= S_IDLE;
            chord_q    <= 3'b000;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            wait_rel_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          chord_q    <= 3'b000;
          op_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op   = alu_op_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_enc_seq
//  Purpose  : Self-checking bench for calc_enc_seq. Randomised chords with
//             random press/release staggering are predicted from the chord
//             rules (OR of pressed buttons -> table lookup, fixed latency of
//             sync + debounce + one FSM cycle), plus directed boundary cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_enc_seq;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnl, btnc, btnr;
  logic       op_ready;
  logic [3:0] alu_op;
  logic       op_valid, busy, overflow;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_ovf  = 1'b0;

  // Expected operation for each chord {l,c,r}.
  logic [3:0] enc_tbl [8];

  calc_enc_seq #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnl     (btnl),
    .btnc     (btnc),
    .btnr     (btnr),
    .op_ready (op_ready),
    .alu_op   (alu_op),
    .op_valid (op_valid),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic set_btns(input logic [2:0] v);
    {btnl, btnc, btnr} = v;
  endtask

  // Waits (bounded) for op_valid, sampling on falling edges.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (op_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("valid_timeout", 0, 1);
  endtask

  // Hand over the pending op and confirm the sequencer settles in IDLE.
  task automatic accept_and_settle();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("accept_drop", {op_valid, busy}, 2'b00);
    repeat (DEB + 8) @(negedge clk);
    check("idle_after", {op_valid, busy}, 2'b00);
    check("ovf_sticky", overflow, exp_ovf);
  endtask

  // One chord transaction. Button k is held over raw cycles [p_k, r_k).
  task automatic run_op(input logic [2:0] mask,
                        input int pl, input int pc, input int pr,
                        input int rl, input int rc, input int rr,
                        input bit ovf, input int bp);
    int         p [3];
    int         r [3];
    int         rmax, pmin, t_seen;
    bit         seen;
    logic [3:0] expv;
    logic [2:0] drv;
    int         b;
    p[2] = pl; p[1] = pc; p[0] = pr;
    r[2] = rl; r[1] = rc; r[0] = rr;
    rmax = 0; pmin = 1000;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        if (r[k] > rmax) rmax = r[k];
        if (p[k] < pmin) pmin = p[k];
      end
    end
    expv   = enc_tbl[mask];
    seen   = 1'b0;
    t_seen = 0;
    for (int t = 0; t <= rmax + 40; t++) begin
      @(negedge clk);
      if (op_valid) begin
        seen     = 1'b1;
        t_seen   = t;
        op_ready = 1'b0;
        break;
      end
      if (t == pmin + DEB + 5) check("busy_collect", busy, 1);
      for (int k = 0; k < 3; k++) drv[k] = mask[k] && (t >= p[k]) && (t < r[k]);
      set_btns(drv);
      op_ready = 1'($urandom_range(0, 1));
    end
    if (!seen) begin
      check("op_timeout", 0, 1);
      set_btns(3'b000);
      return;
    end
    // 2 sync + DEB debounce + 1 FSM edge after the last release.
    check("latency", t_seen - rmax, DEB + 3);
    check("alu_op", alu_op, expv);
    repeat (bp) begin
      @(negedge clk);
      check("hold", {op_valid, alu_op}, {1'b1, expv});
    end
    if (ovf) begin
      b = $urandom_range(0, 2);
      drv = 3'b000;
      drv[b] = 1'b1;
      set_btns(drv);
      repeat (DEB + 3) @(negedge clk);
      set_btns(3'b000);
      repeat (DEB + 6) @(negedge clk);
      exp_ovf = 1'b1;
      check("overflow_set", overflow, 1);
      check("hold_ovf", {op_valid, alu_op}, {1'b1, expv});
    end
    accept_and_settle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit any_busy;
    int k_seen;
    enc_tbl = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h9, 4'hA, 4'h5};
    reset    = 1'b1;
    op_ready = 1'b0;
    set_btns(3'b000);
    repeat (3) @(negedge clk);
    check("reset_outs", {alu_op, op_valid, busy, overflow}, 7'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset", {alu_op, op_valid, busy, overflow}, 7'd0);

    // Pulse one cycle shorter than the debounce window: filtered.
    btnc = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btnc = 1'b0;
    any_busy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      any_busy = any_busy | busy | op_valid;
    end
    check("glitch_filtered", any_busy, 0);

    // Exactly DEB cycles, then a 10-cycle hold: both produce one op.
    run_op(3'b010, 0, 0, 0, 0, DEB, 0, 1'b0, 0);
    run_op(3'b010, 0, 0, 0, 0, 10, 0, 1'b0, 0);

    // All seven chords in order.
    for (int m = 1; m < 8; m++)
      run_op(3'(m), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(20, 35), $urandom_range(20, 35), $urandom_range(20, 35), 1'b0, 0);

    // l then r added 20 cycles later; joint release and staggered release.
    run_op(3'b101, 0, 0, 20, 40, 0, 40, 1'b0, 0);
    run_op(3'b101, 0, 0, 20, 40, 0, 50, 1'b0, 0);

    // Long backpressure, then a discarded press while pending.
    run_op(3'b110, 0, 3, 0, 30, 30, 0, 1'b0, 50);
    run_op(3'b110, 0, 3, 0, 30, 30, 0, 1'b1, 5);

    // Randomised chords, backpressure and discarded presses.
    for (int n = 0; n < 20; n++)
      run_op(3'($urandom_range(1, 7)),
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(20, 35), $urandom_range(20, 35), $urandom_range(20, 35),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 12));

    // Asynchronous reset while an op is pending.
    btnr = 1'b1;
    repeat (10) @(negedge clk);
    btnr = 1'b0;
    wait_valid(ok);
    #2 reset = 1'b1;
    #1 check("async_rst", {op_valid, busy, alu_op, overflow}, 7'd0);
    exp_ovf = 1'b0;

    // Button held through reset counts as a fresh press.
    btnl = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    k_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) begin
        k_seen = k;
        break;
      end
    end
    check("held_rst_latency", k_seen, DEB + 3);
    btnl = 1'b0;
    wait_valid(ok);
    if (ok) begin
      check("held_rst_op", alu_op, 4'b0100);
      accept_and_settle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
